// File: rtl/spi_slave_sync.sv
// SPI slave that runs entirely on iCLK. SCK, SS_n and MOSI are oversampled,
// all four SPI modes are supported, and each frame carries one command word
// (write flag + peripheral select) followed by any number of data words.
module spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int SEL_W       = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSPI_SCK,
  input  logic              iSPI_SS_n,
  input  logic              iSPI_MOSI,
  output logic              oSPI_MISO,
  output logic              oSPI_MISO_OE,
  input  logic [DATA_W-1:0] iTX_DATA,
  output logic              oTX_REQ,
  output logic [DATA_W-1:0] oRX_DATA,
  output logic              oRX_VALID,
  output logic [DATA_W-1:0] oCMD,
  output logic              oCMD_VALID,
  output logic              oCMD_WR,
  output logic [SEL_W-1:0]  oPERIPH_SLCT,
  output logic [CNT_W-1:0]  oWORD_CNT,
  output logic              oFRAME_ACTIVE,
  output logic              oFRAME_END,
  output logic              oFRAME_SHORT
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] REQ_BIT  = BIT_W'(DATA_W / 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, CMD, DATA} stateT;

  stateT                   state;
  stateT                   nextState;
  logic [SYNC_STAGES-1:0]  sckSyncReg;
  logic [SYNC_STAGES-1:0]  ssSyncReg;
  logic [SYNC_STAGES-1:0]  mosiSyncReg;
  logic                    sckSync;
  logic                    ssSync;
  logic                    mosiSync;
  logic                    sckPrev;
  logic                    ssPrev;
  logic                    sckRise;
  logic                    sckFall;
  logic                    leadEdge;
  logic                    trailEdge;
  logic                    ssFall;
  logic                    ssRise;
  logic                    inFrame;
  logic                    startFrame;
  logic                    endFrame;
  logic                    sampleEn;
  logic                    shiftEn;
  logic                    wordDone;
  logic                    reqFire;
  logic [BIT_W-1:0]        bitCnt;
  logic [DATA_W-2:0]       rxShift;
  logic [DATA_W-1:0]       rxWord;
  logic [DATA_W-1:0]       txShift;
  logic [DATA_W-1:0]       txLoadWord;
  logic [DATA_W-1:0]       holdReg;

  assign sckSync  = sckSyncReg[SYNC_STAGES-1];
  assign ssSync   = ssSyncReg[SYNC_STAGES-1];
  assign mosiSync = mosiSyncReg[SYNC_STAGES-1];

  assign sckRise   = sckSync & ~sckPrev;
  assign sckFall   = ~sckSync & sckPrev;
  assign leadEdge  = CPOL ? sckFall : sckRise;
  assign trailEdge = CPOL ? sckRise : sckFall;
  assign ssFall    = ~ssSync & ssPrev;
  assign ssRise    = ssSync & ~ssPrev;

  assign inFrame    = (state != IDLE);
  assign startFrame = (state == IDLE) & ssFall;
  assign endFrame   = inFrame & ssRise;
  // A slave-select release beats any SCK edge seen in the same cycle.
  assign sampleEn   = inFrame & ~ssRise & (CPHA ? trailEdge : leadEdge);
  assign shiftEn    = inFrame & ~ssRise & (CPHA ? leadEdge : trailEdge);
  assign wordDone   = sampleEn & (bitCnt == LAST_BIT);
  assign rxWord     = {rxShift, mosiSync};
  assign reqFire    = sampleEn & (bitCnt == REQ_BIT) &
                      ((state == CMD) | ~oCMD[DATA_W-1]);

  assign oSPI_MISO     = txShift[DATA_W-1];
  assign oSPI_MISO_OE  = inFrame;
  assign oFRAME_ACTIVE = inFrame;
  assign oCMD_WR       = inFrame & oCMD[DATA_W-1];
  assign oPERIPH_SLCT  = inFrame ? oCMD[DATA_W-2 -: SEL_W] : '0;

  // Bring the asynchronous pins into the iCLK domain and keep a delayed copy for edge detection.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sckSyncReg  <= '0;
      ssSyncReg   <= '0;
      mosiSyncReg <= '0;
      sckPrev     <= 1'b0;
      ssPrev      <= 1'b0;
    end else begin
      sckSyncReg  <= {sckSyncReg[SYNC_STAGES-2:0], iSPI_SCK};
      ssSyncReg   <= {ssSyncReg[SYNC_STAGES-2:0], iSPI_SS_n};
      mosiSyncReg <= {mosiSyncReg[SYNC_STAGES-2:0], iSPI_MOSI};
      sckPrev     <= sckSync;
      ssPrev      <= ssSync;
    end
  end

  // Frame state register; ssPrev clears on reset so a new frame needs SS_n seen high first.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  // Next frame state: command word first, data words after, SS_n rise always ends the frame.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (ssFall) nextState = CMD;
      CMD:     if (ssRise) nextState = IDLE;
               else if (wordDone) nextState = DATA;
      DATA:    if (ssRise) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Receive path: bit counter, RX shifter, command latch, data words and frame-end flags.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bitCnt       <= '0;
      rxShift      <= '0;
      oCMD         <= '0;
      oCMD_VALID   <= 1'b0;
      oRX_DATA     <= '0;
      oRX_VALID    <= 1'b0;
      oWORD_CNT    <= '0;
      oFRAME_END   <= 1'b0;
      oFRAME_SHORT <= 1'b0;
    end else begin
      oCMD_VALID   <= 1'b0;
      oRX_VALID    <= 1'b0;
      oFRAME_END   <= 1'b0;
      oFRAME_SHORT <= 1'b0;
      if (startFrame) begin
        bitCnt    <= '0;
        rxShift   <= '0;
        oCMD      <= '0;
        oWORD_CNT <= '0;
      end else if (endFrame) begin
        oFRAME_END   <= 1'b1;
        oFRAME_SHORT <= (bitCnt != '0);
        bitCnt       <= '0;
        rxShift      <= '0;
      end else if (sampleEn) begin
        rxShift <= rxWord[DATA_W-2:0];
        bitCnt  <= (bitCnt == LAST_BIT) ? '0 : bitCnt + BIT_W'(1);
        if (bitCnt == LAST_BIT) begin
          if (state == CMD) begin
            oCMD       <= rxWord;
            oCMD_VALID <= 1'b1;
          end else begin
            oRX_DATA  <= rxWord;
            oRX_VALID <= 1'b1;
            if (oWORD_CNT != CNT_MAX) oWORD_CNT <= oWORD_CNT + CNT_W'(1);
          end
        end
      end
    end
  end

  // Word to put on MISO next: the prefetched read word, or zeros for the command and write frames.
  always_comb begin
    txLoadWord = '0;
    if (state == CMD) begin
      if (!CPHA && !rxWord[DATA_W-1]) txLoadWord = holdReg;
    end else if (!oCMD[DATA_W-1]) begin
      txLoadWord = holdReg;
    end
  end

  // Read prefetch: request mid-word, capture the peripheral's answer one cycle later.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oTX_REQ <= 1'b0;
      holdReg <= '0;
    end else begin
      oTX_REQ <= reqFire;
      if (oTX_REQ) holdReg <= iTX_DATA;
    end
  end

  // MISO shifter: CPHA=0 preloads at the word boundary and skips the trailing edge right after it,
  // CPHA=1 loads on the first leading edge of each word and shifts on the rest.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      txShift <= '0;
    end else if (startFrame || endFrame) begin
      txShift <= '0;
    end else if (!CPHA) begin
      if (wordDone) txShift <= txLoadWord;
      else if (shiftEn && bitCnt != '0) txShift <= {txShift[DATA_W-2:0], 1'b0};
    end else if (shiftEn) begin
      txShift <= (bitCnt == '0) ? txLoadWord : {txShift[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: five instances (modes 0..3, plus mode 0 with a 2-bit word counter),
// an SPI master task and a frame-level model that predicts every strobe and MISO word.
module tb_spi_slave_sync;

  localparam int NDUT  = 5;
  localparam int HALF  = 6;
  localparam int SETUP = 8;

  logic       clk = 1'b0;
  logic       iRST;
  logic       sckPin  [NDUT];
  logic       ssPin   [NDUT];
  logic       mosiPin [NDUT];
  logic [7:0] txData;

  logic       misoA    [NDUT];
  logic       oeA      [NDUT];
  logic       reqA     [NDUT];
  logic [7:0] rxA      [NDUT];
  logic       rxValA   [NDUT];
  logic [7:0] cmdA     [NDUT];
  logic       cmdValA  [NDUT];
  logic       cmdWrA   [NDUT];
  logic [3:0] slctA    [NDUT];
  logic [7:0] wcntA    [NDUT];
  logic       actA     [NDUT];
  logic       endA     [NDUT];
  logic       shortA   [NDUT];

  int compared   = 0;
  int mismatched = 0;

  // frame-level model of what the selected instance must do
  int         sel = 0;
  bit         modelOn = 1'b0;
  logic [7:0] cmdExp;
  logic [7:0] rxExpAll [$];
  bit         shortExp;
  int         cntMax;
  int         rxSeen, reqSeen, cmdSeen, endSeen;
  logic [7:0] txSupplied [$];
  logic [7:0] txPlan [$];
  logic [7:0] misoGot [$];
  logic [7:0] dataWords [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam bit GCPOL = (g == 2) || (g == 3);
    localparam bit GCPHA = (g == 1) || (g == 3);
    localparam int GCNT  = (g == 4) ? 2 : 8;
    logic [GCNT-1:0] wc;
    spi_slave_sync #(
      .DATA_W(8), .SEL_W(4), .CPOL(GCPOL), .CPHA(GCPHA), .SYNC_STAGES(2), .CNT_W(GCNT)
    ) dut (
      .iCLK(clk), .iRST(iRST),
      .iSPI_SCK(sckPin[g]), .iSPI_SS_n(ssPin[g]), .iSPI_MOSI(mosiPin[g]),
      .oSPI_MISO(misoA[g]), .oSPI_MISO_OE(oeA[g]),
      .iTX_DATA(txData), .oTX_REQ(reqA[g]),
      .oRX_DATA(rxA[g]), .oRX_VALID(rxValA[g]),
      .oCMD(cmdA[g]), .oCMD_VALID(cmdValA[g]), .oCMD_WR(cmdWrA[g]),
      .oPERIPH_SLCT(slctA[g]), .oWORD_CNT(wc),
      .oFRAME_ACTIVE(actA[g]), .oFRAME_END(endA[g]), .oFRAME_SHORT(shortA[g])
    );
    assign wcntA[g] = 8'(wc);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkIdleZero(input int d);
    checkOutput("rstCmd",    cmdA[d],    0);
    checkOutput("rstRx",     rxA[d],     0);
    checkOutput("rstWcnt",   wcntA[d],   0);
    checkOutput("rstActive", actA[d],    0);
    checkOutput("rstOe",     oeA[d],     0);
    checkOutput("rstMiso",   misoA[d],   0);
    checkOutput("rstSlct",   slctA[d],   0);
    checkOutput("rstWr",     cmdWrA[d],  0);
    checkOutput("rstStrobes", {cmdValA[d], rxValA[d], reqA[d], endA[d], shortA[d]}, 0);
  endtask

  // Peripheral-mux responder plus per-cycle comparison of the selected instance against the model.
  always @(negedge clk) begin
    if (reqA[sel]) begin
      reqSeen++;
      if (txPlan.size() > 0) txData = txPlan.pop_front();
      else                   txData = 8'($urandom);
      txSupplied.push_back(txData);
    end
    if (endA[sel]) endSeen++;
    if (modelOn) begin
      if (cmdValA[sel]) begin
        cmdSeen++;
        checkOutput("cmd",     cmdA[sel],   cmdExp);
        checkOutput("cmdWr",   cmdWrA[sel], cmdExp[7]);
        checkOutput("cmdSlct", slctA[sel],  cmdExp[6:3]);
      end
      if (rxValA[sel]) begin
        if (rxSeen < rxExpAll.size()) checkOutput("rxData", rxA[sel], rxExpAll[rxSeen]);
        else                          checkOutput("rxExtra", rxSeen + 1, rxExpAll.size());
        rxSeen++;
        checkOutput("wordCnt", wcntA[sel], (rxSeen > cntMax) ? cntMax : rxSeen);
        checkOutput("dataSlct", slctA[sel], cmdExp[6:3]);
      end
      if (endA[sel]) begin
        checkOutput("frameShort", shortA[sel], shortExp);
        checkOutput("endSlct",    slctA[sel],  0);
        checkOutput("endOe",      oeA[sel],    0);
        checkOutput("endActive",  actA[sel],   0);
      end
    end
  end

  // SPI master: sends cmd + dataWords (last one cut to tailBits if nonzero), optional reset at bit abortAt.
  task automatic applyStimulus(input int d, input logic [7:0] cmd, input int tailBits, input int abortAt);
    logic [7:0] words [$];
    logic [7:0] w;
    logic [7:0] cap;
    int nFull, nBits, reqExp;
    bit cpol, cpha, aborted;
    cpol = (d == 2) || (d == 3);
    cpha = (d == 1) || (d == 3);
    words = {cmd};
    foreach (dataWords[k]) words.push_back(dataWords[k]);
    nFull = dataWords.size() - ((tailBits > 0) ? 1 : 0);
    nBits = 8 * (1 + nFull) + tailBits;
    reqExp = 1;
    if (!cmd[7]) reqExp += nFull + ((tailBits > 4) ? 1 : 0);

    sel = d;
    cmdExp = cmd;
    rxExpAll.delete();
    for (int k = 0; k < nFull; k++) rxExpAll.push_back(dataWords[k]);
    shortExp = (tailBits > 0);
    cntMax = (d == 4) ? 3 : 255;
    rxSeen = 0; reqSeen = 0; cmdSeen = 0; endSeen = 0;
    misoGot.delete();
    txSupplied.delete();
    modelOn = 1'b1;
    aborted = 1'b0;
    cap = '0;

    sckPin[d] = cpol;
    w = words[0];
    mosiPin[d] = w[7];
    waitClk(SETUP);
    ssPin[d] = 1'b0;
    waitClk(SETUP);
    for (int i = 0; i < nBits; i++) begin
      if (i == abortAt) begin
        modelOn = 1'b0;
        iRST = 1'b1;
        waitClk(1);
        checkIdleZero(d);
        iRST = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (!cpha) begin
        cap = {cap[6:0], misoA[d]};
        checkOutput("misoOe", oeA[d], 1);
        sckPin[d] = ~cpol;
        waitClk(HALF);
        sckPin[d] = cpol;
        if (i + 1 < nBits) begin
          w = words[(i + 1) / 8];
          mosiPin[d] = w[7 - ((i + 1) % 8)];
        end
        waitClk(HALF);
      end else begin
        sckPin[d] = ~cpol;
        w = words[i / 8];
        mosiPin[d] = w[7 - (i % 8)];
        waitClk(HALF);
        cap = {cap[6:0], misoA[d]};
        checkOutput("misoOe", oeA[d], 1);
        sckPin[d] = cpol;
        waitClk(HALF);
      end
      if (i % 8 == 7) misoGot.push_back(cap);
    end
    waitClk(SETUP);
    ssPin[d] = 1'b1;

    if (aborted) begin
      waitClk(30);
      checkOutput("noFrameEndAfterReset", endSeen, 0);
    end else begin
      for (int k = 0; k < 40 && endSeen == 0; k++) @(negedge clk);
      checkOutput("frameEndPulses", endSeen, 1);
      checkOutput("cmdPulses",      cmdSeen, 1);
      checkOutput("rxPulses",       rxSeen,  nFull);
      checkOutput("txReqPulses",    reqSeen, reqExp);
      checkOutput("misoWords",      misoGot.size(), nFull + 1);
      for (int k = 0; k < misoGot.size(); k++) begin
        if (k == 0 || cmd[7])            checkOutput("misoZero", misoGot[k], 0);
        else if (k - 1 < txSupplied.size()) checkOutput("misoRead", misoGot[k], txSupplied[k - 1]);
        else                              checkOutput("misoSupply", txSupplied.size(), k);
      end
    end
    waitClk(4);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d, nData, tail;
    logic [7:0] cmd;
    iRST = 1'b1;
    txData = '0;
    for (int g = 0; g < NDUT; g++) begin
      sckPin[g]  = (g == 2) || (g == 3);
      ssPin[g]   = 1'b1;
      mosiPin[g] = 1'b0;
    end
    waitClk(5);
    for (int g = 0; g < NDUT; g++) checkIdleZero(g);
    iRST = 1'b0;
    waitClk(6);

    $display("[TB] mode 0 write frame");
    dataWords = {8'h3C, 8'hC3};
    applyStimulus(0, 8'hA8, 0, -1);
    checkOutput("m0LitCmd",  cmdA[0],  8'hA8);
    checkOutput("m0LitRx",   rxA[0],   8'hC3);
    checkOutput("m0LitWcnt", wcntA[0], 2);

    $display("[TB] mode 3 read frame");
    txPlan = {8'h5A, 8'h96, 8'h00};
    dataWords = {8'hFF, 8'hFF};
    applyStimulus(3, 8'h18, 0, -1);
    checkOutput("m3LitReqs",  reqSeen, 3);
    checkOutput("m3LitMiso0", misoGot[0], 8'h00);
    checkOutput("m3LitMiso1", misoGot[1], 8'h5A);
    checkOutput("m3LitMiso2", misoGot[2], 8'h96);
    txPlan.delete();

    $display("[TB] modes 1 and 2 write frame");
    for (int m = 1; m <= 2; m++) begin
      dataWords = {8'h3C, 8'hC3};
      applyStimulus(m, 8'hA8, 0, -1);
      checkOutput("m12LitCmd", cmdA[m], 8'hA8);
      checkOutput("m12LitRx",  rxA[m],  8'hC3);
    end

    $display("[TB] short frame then clean command");
    dataWords = {8'h11, 8'h22};
    applyStimulus(0, 8'h90, 3, -1);
    checkOutput("shortLitRx", rxA[0], 8'h11);
    dataWords = {8'h77};
    applyStimulus(0, 8'h28, 0, -1);
    checkOutput("afterShortLitCmd", cmdA[0], 8'h28);

    $display("[TB] reset mid data word");
    dataWords = {8'h55, 8'h66};
    applyStimulus(0, 8'hC8, 0, 11);
    dataWords = {8'h01};
    applyStimulus(0, 8'hB0, 0, -1);
    checkOutput("afterResetLitRx", rxA[0], 8'h01);

    $display("[TB] word counter saturation");
    dataWords = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    applyStimulus(4, 8'h88, 0, -1);
    checkOutput("satLitWcnt", wcntA[4], 3);
    checkOutput("satLitRx",   rxA[4],   8'h50);

    $display("[TB] random frames");
    for (int r = 0; r < 12; r++) begin
      d     = $urandom_range(0, 4);
      cmd   = 8'($urandom);
      nData = $urandom_range(0, 4);
      tail  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      dataWords.delete();
      for (int k = 0; k < nData + ((tail > 0) ? 1 : 0); k++) dataWords.push_back(8'($urandom));
      applyStimulus(d, cmd, tail, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
